// File: rtl/cplx_frame_feeder.sv
// Buffers packed complex samples in a small FIFO and feeds them, one frame of FRAME_LEN at a time, to a clear-on-zero accumulator.
// Optional macro CPLX_FEEDER_PRESCALE_EN: arithmetic >>>2 on each component before output.
module cplx_frame_feeder #(
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] val_out,
    output logic        ce,
    output logic        frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {CLEAR, STREAM, DONE} state_t;

    state_t         state;
    logic [7:0]     count;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    occ;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [31:0]    head;
    logic [31:0]    word;

    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == '0);
    assign s_ready = !rst && !full;
    assign push    = s_valid && s_ready;
    assign pop     = (state == STREAM) && !empty;
    assign head    = mem[rd_ptr];

`ifdef CPLX_FEEDER_PRESCALE_EN
    logic signed [15:0] re_sh;
    logic signed [15:0] im_sh;
    assign re_sh = $signed(head[31:16]) >>> 2;
    assign im_sh = $signed(head[15:0]) >>> 2;
    assign word  = {re_sh, im_sh};
`else
    assign word  = head;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            count      <= '0;
            val_out    <= '0;
            ce         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    val_out    <= '0;
                    ce         <= 1'b0;
                    frame_done <= 1'b0;
                    count      <= '0;
                    state      <= STREAM;
                end
                STREAM: begin
                    frame_done <= 1'b0;
                    if (pop) begin
                        count <= count + 1'b1;
                        // A zero word would clear the accumulator, so zeros are counted but not emitted.
                        if (word != '0) begin
                            val_out <= word;
                            ce      <= 1'b1;
                        end else begin
                            ce      <= 1'b0;
                        end
                        if (count == LAST_IDX) state <= DONE;
                    end else begin
                        ce <= 1'b0;
                    end
                end
                DONE: begin
                    ce         <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= CLEAR;
                end
                default: begin
                    ce         <= 1'b0;
                    frame_done <= 1'b0;
                    state      <= CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_frame_feeder.sv
// Randomized bench for cplx_frame_feeder: scoreboard of accepted samples plus a clear-on-zero accumulator model.
module tb_cplx_frame_feeder;
    localparam int FRAME_LEN  = 8;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] val_out;
    logic        ce;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] in_q[$];
    int          pos = 0;
    logic [31:0] exp_sum = '0;
    logic [31:0] acc = '0;
    logic [31:0] prev_val = '0;
    logic        prev_fd = 1'b0;
    logic        prev_ce = 1'b0;
    logic        last_nz = 1'b0;
    int          frames = 0;
    logic [31:0] last_sum = '0;
    logic        saw_not_ready = 1'b0;

    cplx_frame_feeder #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .val_out(val_out), .ce(ce), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] proc(input logic [31:0] w);
`ifdef CPLX_FEEDER_PRESCALE_EN
        logic signed [15:0] re;
        logic signed [15:0] im;
        re = $signed(w[31:16]) >>> 2;
        im = $signed(w[15:0]) >>> 2;
        return {re, im};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] re;
        logic [15:0] im;
        re = a[31:16] + b[31:16];
        im = a[15:0] + b[15:0];
        return {re, im};
    endfunction

    // Output monitor: every sample accepted must show up in order, zeros silently, frames of FRAME_LEN.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst) begin
            in_q.delete();
            pos = 0; exp_sum = '0; acc = '0; prev_val = '0;
            prev_fd = 1'b0; prev_ce = 1'b0; last_nz = 1'b0;
        end else begin
            checks++;
            if (prev_fd) begin
                if (val_out !== 32'h0 || ce !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_word: val_out=%h ce=%b, required 00000000 ce=0", val_out, ce);
                end
            end else if (ce === 1'b0) begin
                if (val_out !== prev_val) begin
                    errors++;
                    $display("FAIL hold: val_out=%h, required %h", val_out, prev_val);
                end
            end
            if (ce === 1'b1) begin
                while (in_q.size() > 0 && in_q[0] == 32'h0 && pos < FRAME_LEN) begin
                    void'(in_q.pop_front());
                    pos++;
                    last_nz = 1'b0;
                end
                checks++;
                if (pos >= FRAME_LEN || in_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_ce: ce=1 val_out=%h with pos=%0d queued=%0d", val_out, pos, in_q.size());
                end else begin
                    exp_w = in_q.pop_front();
                    if (val_out !== exp_w) begin
                        errors++;
                        $display("FAIL data: val_out=%h, required %h", val_out, exp_w);
                    end
                    exp_sum = cadd(exp_sum, exp_w);
                    pos++;
                    last_nz = 1'b1;
                end
                acc = cadd(acc, val_out);
            end else if (val_out == 32'h0) begin
                acc = '0;
            end
            if (frame_done === 1'b1) begin
                while (pos < FRAME_LEN && in_q.size() > 0 && in_q[0] == 32'h0) begin
                    void'(in_q.pop_front());
                    pos++;
                    last_nz = 1'b0;
                end
                checks += 2;
                if (pos != FRAME_LEN) begin
                    errors++;
                    $display("FAIL frame_len: samples in frame=%0d, required %0d", pos, FRAME_LEN);
                end
                if (acc !== exp_sum) begin
                    errors++;
                    $display("FAIL frame_sum: downstream sum=%h, required %h", acc, exp_sum);
                end
                if (last_nz) begin
                    checks++;
                    if (prev_ce !== 1'b1) begin
                        errors++;
                        $display("FAIL done_timing: ce before frame_done=%b, required 1", prev_ce);
                    end
                end
                frames++;
                last_sum = acc;
                pos = 0;
                exp_sum = '0;
            end
            prev_fd = frame_done;
            prev_ce = ce;
            prev_val = val_out;
        end
    end

    // Called at a negedge; leaves s_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] w);
        bit ok = 0;
        s_data = w;
        s_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (s_ready) begin
                in_q.push_back(proc(w));
                ok = 1;
            end else begin
                saw_not_ready = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance within 300 cycles", w);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data = '0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 1000 && frames < target; i++) @(negedge clk);
        checks++;
        if (frames < target) begin
            errors++;
            $display("FAIL frame_timeout: frames=%0d, required %0d", frames, target);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (val_out !== 32'h0 || ce !== 1'b0 || frame_done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: val_out=%h ce=%b fd=%b s_ready=%b, required 0 0 0 0", val_out, ce, frame_done, s_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || val_out !== 32'h0 || ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b val_out=%h ce=%b, required 1 00000000 0", s_ready, val_out, ce);
        end
    endtask

    task automatic test_basic();
        int f0 = frames;
        for (int i = 0; i < FRAME_LEN; i++) send(32'h0001_0002);
        idle();
        wait_frames(f0 + 1);
        checks++;
`ifndef CPLX_FEEDER_PRESCALE_EN
        if (last_sum !== 32'h0008_0010) begin
            errors++;
            $display("FAIL basic_sum: sum=%h, required 00080010", last_sum);
        end
`else
        if (last_sum !== 32'h0000_0000) begin
            errors++;
            $display("FAIL basic_sum: sum=%h, required 00000000", last_sum);
        end
`endif
    endtask

    task automatic test_zero_sample();
        int f0 = frames;
        send(32'h0003_0003);
        send(32'h0000_0000);
        send(32'h0001_FFFF);
        for (int i = 0; i < 5; i++) send(32'h0001_0001);
        idle();
        wait_frames(f0 + 1);
`ifndef CPLX_FEEDER_PRESCALE_EN
        checks++;
        if (last_sum !== 32'h0009_0007) begin
            errors++;
            $display("FAIL zero_sum: sum=%h, required 00090007", last_sum);
        end
`endif
    endtask

    task automatic test_first_zero();
        int f0 = frames;
        send(32'h0000_0000);
        for (int i = 1; i < FRAME_LEN; i++) send($urandom_range(1, 255) << 16 | $urandom_range(1, 255));
        idle();
        wait_frames(f0 + 1);
    endtask

    task automatic test_back_to_back();
        int f0 = frames;
        saw_not_ready = 1'b0;
        for (int i = 0; i < 5 * FRAME_LEN; i++) send($urandom);
        idle();
        wait_frames(f0 + 5);
        checks += 2;
        if (saw_not_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_full: s_ready never dropped, required a drop with %0d buffered", FIFO_DEPTH);
        end
        if (in_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d samples left, required 0", in_q.size());
        end
    endtask

    task automatic test_random();
        int f0 = frames;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            if ($urandom_range(0, 3) == 0) send(32'h0);
            else send($urandom);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        idle();
        wait_frames(f0 + 4);
        checks++;
        if (in_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d samples left, required 0", in_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        for (int i = 0; i < 3; i++) send(32'h0005_0006);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (val_out !== 32'h0 || ce !== 1'b0 || frame_done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: val_out=%h ce=%b fd=%b s_ready=%b, required 0 0 0 0", val_out, ce, frame_done, s_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: s_ready=%b, required 1", s_ready);
        end
        f0 = frames;
        for (int i = 0; i < FRAME_LEN; i++) send(32'h0002_0001);
        idle();
        wait_frames(f0 + 1);
`ifndef CPLX_FEEDER_PRESCALE_EN
        checks++;
        if (last_sum !== 32'h0010_0008) begin
            errors++;
            $display("FAIL mid_sum: sum=%h, required 00100008", last_sum);
        end
`endif
    endtask

`ifdef CPLX_FEEDER_PRESCALE_EN
    task automatic test_prescale();
        int f0 = frames;
        send(32'h0004_FFF8);
        send(32'h0003_0002);
        for (int i = 2; i < FRAME_LEN; i++) send(32'h0004_FFF8);
        idle();
        wait_frames(f0 + 1);
        checks++;
        if (last_sum !== 32'h0007_FFF2) begin
            errors++;
            $display("FAIL prescale_sum: sum=%h, required 0007FFF2", last_sum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_sample();
        test_first_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef CPLX_FEEDER_PRESCALE_EN
        test_prescale();
`endif
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
